// File: rtl/mul_issue_controller_pkg.sv
// Shared types for the integer multiply issue path: op encoding, data widths,
// and the pipeline stage record carried from S1 to SL.
package mul_issue_controller_pkg;

    localparam int unsigned MUL_LATENCY_DEFAULT = 3;
    localparam int unsigned TAG_WIDTH_MAX       = 16;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MulOp;

    typedef logic [31:0] BasicData;
    typedef logic [65:0] MulDivResult;

    // S1 payload packs {2'b00, op1, op2}; S2..SL payload is the 66-bit product.
    typedef struct packed {
        logic                     valid;
        MulOp                     op;
        logic [TAG_WIDTH_MAX-1:0] tag;
        MulDivResult              payload;
    } mul_stage_t;

    // Returns {signOp1, signOp2}.
    function automatic logic [1:0] sign_config(MulOp op);
        case (op)
            MULH:    return 2'b11;
            MULHSU:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mul_issue_controller_multiplier.sv
// Shared Multiplier primitive: 33x33 signed product of sign-controlled operands.
module mul_issue_controller_multiplier
    import mul_issue_controller_pkg::*;
(
    input  BasicData    op1,
    input  BasicData    op2,
    input  logic        signOp1,
    input  logic        signOp2,
    output MulDivResult product
);

    logic signed [32:0] a;
    logic signed [32:0] b;
    logic signed [65:0] a_ext;
    logic signed [65:0] b_ext;

    assign a     = {signOp1 & op1[31], op1};
    assign b     = {signOp2 & op2[31], op2};
    assign a_ext = 66'(a);
    assign b_ext = 66'(b);
    assign product = a_ext * b_ext;

endmodule

// File: rtl/mul_issue_controller.sv
// Multiply issue controller: valid/ready accept into S1, product registered in S2,
// pass-through to SL, result-half select, with global stall and flush.
module mul_issue_controller
    import mul_issue_controller_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEFAULT,
    parameter int unsigned TAG_WIDTH   = 6
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  MulOp                 reqOp,
    input  BasicData             reqOp1,
    input  BasicData             reqOp2,
    input  logic [TAG_WIDTH-1:0] reqTag,
    output logic                 respValid,
    input  logic                 respReady,
    output BasicData             respData,
    output logic [TAG_WIDTH-1:0] respTag
);

    if (MUL_LATENCY < 2 || TAG_WIDTH > TAG_WIDTH_MAX || TAG_WIDTH < 1) begin : g_bad_param
        $error("mul_issue_controller: illegal MUL_LATENCY or TAG_WIDTH");
    end

    mul_stage_t  s1;
    mul_stage_t  stage [2:MUL_LATENCY];
    mul_stage_t  last;
    logic        advance;
    logic        accept;
    logic        signOp1;
    logic        signOp2;
    MulDivResult product;
    logic        unused_bits;

    assign last     = stage[MUL_LATENCY];
    assign advance  = !last.valid || respReady;
    assign reqReady = advance && !flush && !rst;
    assign accept   = reqValid && reqReady;

    // Data fields load on every advance; only valid needs clearing on flush/reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1.valid <= 1'b0;
        end else if (advance) begin
            s1.valid   <= accept;
            s1.op      <= reqOp;
            s1.tag     <= TAG_WIDTH_MAX'(reqTag);
            s1.payload <= {2'b00, reqOp1, reqOp2};
        end
    end

    assign {signOp1, signOp2} = sign_config(s1.op);

    mul_issue_controller_multiplier u_multiplier (
        .op1     (s1.payload[63:32]),
        .op2     (s1.payload[31:0]),
        .signOp1 (signOp1),
        .signOp2 (signOp2),
        .product (product)
    );

    for (genvar k = 2; k <= MUL_LATENCY; k++) begin : g_stage
        mul_stage_t r;
        mul_stage_t src;

        if (k == 2) begin : g_first
            assign src = '{valid: s1.valid, op: s1.op, tag: s1.tag, payload: product};
        end else begin : g_pass
            assign src = stage[k-1];
        end

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r.valid <= 1'b0;
            end else if (advance) begin
                r <= src;
            end
        end

        assign stage[k] = r;
    end

    assign respValid = last.valid;
    assign respData  = (last.op == MUL) ? last.payload[31:0] : last.payload[63:32];
    assign respTag   = last.tag[TAG_WIDTH-1:0];

    assign unused_bits = ^{s1.payload[65:64], last.payload[65:64], last.tag};

endmodule
